// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line controller.
// Holds the FSM state enum, response-type encodings, frame lengths and the CRC7 step.
package sd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StTxPre,
      StTx,
      StTurn,
      StWaitStart,
      StRx,
      StGap
   } state_t;

   localparam logic [1:0] RESP_NONE  = 2'd0;
   localparam logic [1:0] RESP_SHORT = 2'd1;
   localparam logic [1:0] RESP_LONG  = 2'd2;

   localparam int unsigned CmdLen   = 48;
   localparam int unsigned ShortLen = 48;
   localparam int unsigned LongLen  = 136;

   // x^7 + x^3 + 1, implicit x^7 term
   localparam logic [6:0] Crc7Poly = 7'h09;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, MSB first, init 0. Clear has priority over enable.
module sd_crc7 (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);
   import sd_pkg::*;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= crc7_step(crc, bit_in);
      end
   end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD-host CMD-line controller: command serialization, turnaround, response capture.
// Define SD_CMD_CRC_CHECK_EN to check the received response CRC7 (resp_crc_err).
module sd_cmd_ctrl #(
   parameter int unsigned NCR_MAX = 64,
   parameter int unsigned NCC_MIN = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   output logic         resp_valid,
   output logic [127:0] resp_data,
   output logic         resp_timeout,
   output logic         resp_crc_err,
   output logic         pad_oe,
   output logic         pad_enable,
   output logic         pad_dout,
   input  logic         pad_din
);
   import sd_pkg::*;

   localparam logic [15:0] NcrLast = 16'(NCR_MAX - 1);
   localparam logic [15:0] NccLast = 16'(NCC_MIN - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [39:0] frame;
   logic [1:0]  rtype;
   logic [6:0]  tx_crc;
   logic        accept;
   logic        is_long;
   logic        tx_feed;
   logic        tx_bit;
   logic [15:0] rx_last;

   assign accept  = cmd_valid && cmd_ready;
   assign is_long = (rtype == RESP_LONG);
   assign rx_last = is_long ? 16'(LongLen - 1) : 16'(ShortLen - 1);
   assign tx_feed = (state == StTxPre) || ((state == StTx) && (cnt < 16'd40));

   // cnt is the index of the frame bit to be driven next
   always_comb begin
      tx_bit = 1'b1;
      if (cnt < 16'd40) begin
         tx_bit = frame[6'(6'd39 - cnt[5:0])];
      end else if (cnt < 16'd47) begin
         tx_bit = tx_crc[3'(6'd46 - cnt[5:0])];
      end
   end

   sd_crc7 u_tx_crc (
      .clock  (clock),
      .reset_n(reset_n),
      .clear  (accept),
      .enable (tx_feed),
      .bit_in (tx_bit),
      .crc    (tx_crc)
   );

`ifdef SD_CMD_CRC_CHECK_EN
   logic [6:0]  rx_crc;
   logic [15:0] rx_idx;
   logic        rx_feed;

   // Short: CRC over frame bits 0..39; long: over bits 8..127 (resp_data[127:8])
   always_comb begin
      rx_idx  = (state == StRx) ? cnt : 16'd0;
      rx_feed = 1'b0;
      if (((state == StWaitStart) && !pad_din) || (state == StRx)) begin
         rx_feed = is_long ? ((rx_idx >= 16'd8) && (rx_idx <= 16'd127)) : (rx_idx <= 16'd39);
      end
   end

   sd_crc7 u_rx_crc (
      .clock  (clock),
      .reset_n(reset_n),
      .clear  (accept),
      .enable (rx_feed),
      .bit_in (pad_din),
      .crc    (rx_crc)
   );
`else
   assign resp_crc_err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= StIdle;
         cnt          <= '0;
         frame        <= '0;
         rtype        <= RESP_NONE;
         cmd_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         resp_timeout <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
         resp_crc_err <= 1'b0;
`endif
         pad_oe       <= 1'b0;
         pad_enable   <= 1'b0;
         pad_dout     <= 1'b1;
      end else begin
         resp_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (accept) begin
                  state        <= StTxPre;
                  frame        <= {2'b01, cmd_index, cmd_arg};
                  rtype        <= resp_type;
                  cnt          <= '0;
                  cmd_ready    <= 1'b0;
                  resp_data    <= '0;
                  resp_timeout <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
                  resp_crc_err <= 1'b0;
`endif
                  pad_oe       <= 1'b1;
                  pad_enable   <= 1'b1;
                  pad_dout     <= 1'b1;
               end
            end
            StTxPre, StTx: begin
               if (cnt == 16'(CmdLen)) begin
                  pad_dout <= 1'b1;
                  pad_oe   <= 1'b0;
                  cnt      <= '0;
                  if (rtype == RESP_NONE) begin
                     state      <= StGap;
                     pad_enable <= 1'b0;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= StTurn;
                  end
               end else begin
                  state    <= StTx;
                  pad_dout <= tx_bit;
                  cnt      <= cnt + 16'd1;
               end
            end
            StTurn: begin
               if (cnt == 16'd1) begin
                  state <= StWaitStart;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StWaitStart: begin
               if (!pad_din) begin
                  state     <= StRx;
                  cnt       <= 16'd1;
                  resp_data <= {resp_data[126:0], 1'b0};
               end else if (cnt == NcrLast) begin
                  state        <= StGap;
                  cnt          <= '0;
                  pad_enable   <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StRx: begin
               resp_data <= {resp_data[126:0], pad_din};
               if (cnt == rx_last) begin
                  state      <= StGap;
                  cnt        <= '0;
                  pad_enable <= 1'b0;
                  resp_valid <= 1'b1;
`ifdef SD_CMD_CRC_CHECK_EN
                  // resp_data[6:0] becomes resp_data[7:1] after this final shift
                  resp_crc_err <= (rx_crc != resp_data[6:0]);
`endif
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            StGap: begin
               if (cnt == NccLast) begin
                  state     <= StIdle;
                  cmd_ready <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: command frames, short/long responses, timeout, reset.
module tb_sd_cmd_ctrl;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [5:0]   cmd_index = '0;
   logic [31:0]  cmd_arg = '0;
   logic [1:0]   resp_type = '0;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic         resp_timeout;
   logic         resp_crc_err;
   logic         pad_oe;
   logic         pad_enable;
   logic         pad_dout;
   logic         pad_din = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;

   // results recorded by do_cmd
   logic [47:0]  tx_frame;
   int           valid_cyc;
   int           ready_cyc;
   int           valid_cnt;
   logic [127:0] got_data;
   logic         got_to;
   logic         got_err;
   logic         pre_ok;
   logic [1:0]   turn_st;
   logic         exp_err_bad;

   sd_cmd_ctrl #(.NCR_MAX(64), .NCC_MIN(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_index   (cmd_index),
      .cmd_arg     (cmd_arg),
      .resp_type   (resp_type),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_timeout(resp_timeout),
      .resp_crc_err(resp_crc_err),
      .pad_oe      (pad_oe),
      .pad_enable  (pad_enable),
      .pad_dout    (pad_dout),
      .pad_din     (pad_din)
   );

   always #5 clock = ~clock;

   // Used only to build the long-response stimulus.
   function automatic logic [6:0] crc7_model(input logic [119:0] d);
      logic [6:0] r;
      logic       fb;
      r = '0;
      for (int i = 119; i >= 0; i--) begin
         fb = d[i] ^ r[6];
         r  = {r[5:0], 1'b0};
         if (fb) r = r ^ 7'h09;
      end
      return r;
   endfunction

   // Cycle 0 = accept cycle. Card reply starts in cycle 52+delay (delay<0: silent).
   task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [135:0] reply, input int len, input int delay);
      int c;
      tx_frame  = '0;
      valid_cyc = -1;
      ready_cyc = -1;
      valid_cnt = 0;
      got_data  = '0;
      got_to    = 1'b0;
      got_err   = 1'b0;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_index = idx;
      cmd_arg   = arg;
      resp_type = rt;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      c = 1;
      pre_ok = pad_oe && pad_enable && pad_dout && !cmd_ready;
      while (ready_cyc < 0 && c < 400) begin
         if (delay >= 0 && c >= 52 + delay && c < 52 + delay + len)
            pad_din = reply[len - 1 - (c - 52 - delay)];
         else
            pad_din = 1'b1;
         @(posedge clock);
         #1;
         c++;
         if (c >= 2 && c <= 49) tx_frame[49 - c] = pad_dout;
         if (c == 50) turn_st = {pad_oe, pad_enable};
         if (resp_valid) begin
            valid_cnt++;
            if (valid_cyc < 0) begin
               valid_cyc = c;
               got_data  = resp_data;
               got_to    = resp_timeout;
               got_err   = resp_crc_err;
            end
         end
         if (cmd_ready && ready_cyc < 0) ready_cyc = c;
      end
      pad_din = 1'b1;
      tests_run++;
      if (ready_cyc < 0) begin
         tests_failed++;
         $display("FAIL cmd_done: cmd_ready never returned within 400 cycles");
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if ({cmd_ready, resp_valid, resp_timeout, resp_crc_err, pad_oe, pad_enable, pad_dout}
          !== 7'b1000001) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b, want 1000001",
                  {cmd_ready, resp_valid, resp_timeout, resp_crc_err, pad_oe, pad_enable, pad_dout});
      end
      tests_run++;
      if (resp_data !== 128'd0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h, want 0", resp_data);
      end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_cmd0_none;
      do_cmd(6'd0, 32'd0, 2'd0, '0, 0, -1);
      tests_run++;
      if (pre_ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL cmd0_txpre: got %b, want 1", pre_ok);
      end
      tests_run++;
      if (tx_frame !== 48'h400000000095) begin
         tests_failed++;
         $display("FAIL cmd0_frame: got %h, want 400000000095", tx_frame);
      end
      tests_run++;
      if (valid_cyc !== 50 || valid_cnt !== 1) begin
         tests_failed++;
         $display("FAIL cmd0_valid: got cyc %0d cnt %0d, want cyc 50 cnt 1", valid_cyc, valid_cnt);
      end
      tests_run++;
      if ({got_to, got_err, turn_st} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL cmd0_flags: got %b, want 0000", {got_to, got_err, turn_st});
      end
      tests_run++;
      if (ready_cyc !== 58) begin
         tests_failed++;
         $display("FAIL cmd0_ready: got %0d, want 58", ready_cyc);
      end
   endtask

   task automatic test_cmd8_short;
      do_cmd(6'd8, 32'h000001AA, 2'd1, {88'd0, 48'h08000001AA13}, 48, 5);
      tests_run++;
      if (tx_frame !== 48'h48000001AA87) begin
         tests_failed++;
         $display("FAIL cmd8_frame: got %h, want 48000001aa87", tx_frame);
      end
      tests_run++;
      if (turn_st !== 2'b01) begin
         tests_failed++;
         $display("FAIL cmd8_turn: got oe/en %b, want 01", turn_st);
      end
      tests_run++;
      if (valid_cyc !== 105 || valid_cnt !== 1) begin
         tests_failed++;
         $display("FAIL cmd8_valid: got cyc %0d cnt %0d, want cyc 105 cnt 1", valid_cyc, valid_cnt);
      end
      tests_run++;
      if (got_data !== {80'd0, 48'h08000001AA13}) begin
         tests_failed++;
         $display("FAIL cmd8_data: got %h, want 08000001aa13", got_data);
      end
      tests_run++;
      if ({got_to, got_err} !== 2'b00) begin
         tests_failed++;
         $display("FAIL cmd8_flags: got %b, want 00", {got_to, got_err});
      end
   endtask

   task automatic test_crc_error;
`ifdef SD_CMD_CRC_CHECK_EN
      exp_err_bad = 1'b1;
`else
      exp_err_bad = 1'b0;
`endif
      do_cmd(6'd8, 32'h000001AA, 2'd1, {88'd0, 48'h08000001AA11}, 48, 5);
      tests_run++;
      if (got_err !== exp_err_bad || got_to !== 1'b0) begin
         tests_failed++;
         $display("FAIL crc_err: got err %b to %b, want err %b to 0", got_err, got_to, exp_err_bad);
      end
      tests_run++;
      if (got_data !== {80'd0, 48'h08000001AA11}) begin
         tests_failed++;
         $display("FAIL crc_err_data: got %h, want 08000001aa11", got_data);
      end
   endtask

   task automatic test_cmd2_long;
      logic [119:0] cid;
      logic [6:0]   crc;
      logic [135:0] reply;
      cid   = 120'h035344534430344780123456789ABC;
      crc   = crc7_model(cid);
      reply = {8'h3F, cid, crc, 1'b1};
      do_cmd(6'd2, 32'd0, 2'd2, reply, 136, 2);
      tests_run++;
      if (tx_frame !== 48'h42000000004D) begin
         tests_failed++;
         $display("FAIL cmd2_frame: got %h, want 42000000004d", tx_frame);
      end
      tests_run++;
      if (got_data !== reply[127:0] || got_err !== 1'b0 || got_to !== 1'b0) begin
         tests_failed++;
         $display("FAIL cmd2_data: got %h err %b to %b, want %h err 0 to 0",
                  got_data, got_err, got_to, reply[127:0]);
      end
      tests_run++;
      if (valid_cyc !== 190 || ready_cyc - valid_cyc !== 8) begin
         tests_failed++;
         $display("FAIL cmd2_timing: got valid %0d ready %0d, want 190 198", valid_cyc, ready_cyc);
      end
   endtask

   task automatic test_timeout;
      do_cmd(6'd55, 32'd0, 2'd1, '0, 0, -1);
      tests_run++;
      if (tx_frame !== 48'h770000000065) begin
         tests_failed++;
         $display("FAIL to_frame: got %h, want 770000000065", tx_frame);
      end
      tests_run++;
      if (valid_cyc !== 116 || got_to !== 1'b1 || got_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL to_valid: got cyc %0d to %b err %b, want 116 1 0", valid_cyc, got_to, got_err);
      end
      tests_run++;
      if (got_data !== 128'd0) begin
         tests_failed++;
         $display("FAIL to_data: got %h, want 0", got_data);
      end
   endtask

   task automatic test_start_last_cycle;
      do_cmd(6'd8, 32'h000001AA, 2'd3, {88'd0, 48'h08000001AA13}, 48, 63);
      tests_run++;
      if (valid_cyc !== 163 || got_to !== 1'b0 || got_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL late_start: got cyc %0d to %b err %b, want 163 0 0", valid_cyc, got_to, got_err);
      end
      tests_run++;
      if (got_data !== {80'd0, 48'h08000001AA13}) begin
         tests_failed++;
         $display("FAIL late_start_data: got %h, want 08000001aa13", got_data);
      end
   endtask

   task automatic test_reset_mid_tx;
      int pulses;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_index = 6'd0;
      cmd_arg   = 32'd0;
      resp_type = 2'd0;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      repeat (21) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ({pad_oe, pad_enable, cmd_ready, resp_valid} !== 4'b0010) begin
         tests_failed++;
         $display("FAIL rst_mid: got oe/en/rdy/vld %b, want 0010",
                  {pad_oe, pad_enable, cmd_ready, resp_valid});
      end
      @(negedge clock);
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (resp_valid) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL rst_no_valid: got %0d pulses, want 0", pulses);
      end
      do_cmd(6'd0, 32'd0, 2'd0, '0, 0, -1);
      tests_run++;
      if (tx_frame !== 48'h400000000095 || valid_cyc !== 50) begin
         tests_failed++;
         $display("FAIL rst_recover: got %h cyc %0d, want 400000000095 cyc 50", tx_frame, valid_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_cmd0_none();
      test_cmd8_short();
      test_crc_error();
      test_cmd2_long();
      test_timeout();
      test_start_last_cycle();
      test_reset_mid_tx();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
